// File: rtl/product_accumulator_if.sv
// Product/accumulator handshake bundle: product stream in, block sum out.
// master = upstream/downstream environment, slave = accumulator.
interface product_accumulator_if #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 4
);
    logic [7:0]       p_in;
    logic             p_valid;
    logic             p_ready;
    logic [CNT_W-1:0] len;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             ovf;

    modport master (
        output p_in, p_valid, len, acc_ready,
        input  p_ready, acc_out, acc_valid, ovf
    );

    modport slave (
        input  p_in, p_valid, len, acc_ready,
        output p_ready, acc_out, acc_valid, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Block accumulator for 8-bit products from a 4x4 array multiplier.
// Sums len products (len=0 treated as 1) and presents the sum with a
// valid/ready handshake. Build option PRODUCT_ACCUMULATOR_SATURATE_EN
// clamps the sum on overflow; otherwise the sum wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] len_q, len_q_next;
    logic             ovf_q, ovf_next;
    logic             p_ready_q;
    logic             acc_valid_q;

    logic [SUM_W-1:0] sum;
    logic             carry;
    logic             take;
    logic [CNT_W-1:0] cnt_inc;

    // Widened sum, product transfer strobe and counter increment
    always_comb begin
        sum     = {1'b0, acc} + SUM_W'(bus.p_in);
        carry   = sum[ACC_W];
        take    = bus.p_valid & p_ready_q;
        cnt_inc = cnt + CNT_W'(1);
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        len_q_next = len_q;
        ovf_next   = ovf_q;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_next   = ACC_W'(bus.p_in);
                    cnt_next   = CNT_W'(1);
                    len_q_next = bus.len;
                    ovf_next   = 1'b0;
                    state_next = (bus.len <= CNT_W'(1)) ? DONE : ACC;
                end
            end
            ACC: begin
                if (take) begin
                    ovf_next = ovf_q | carry;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                    acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                    acc_next = sum[ACC_W-1:0];
`endif
                    cnt_next = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.acc_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and handshake output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            p_ready_q   <= 1'b1;
            acc_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
            len_q       <= len_q_next;
            ovf_q       <= ovf_next;
            p_ready_q   <= (state_next != DONE);
            acc_valid_q <= (state_next == DONE);
        end
    end

    assign bus.p_ready   = p_ready_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf_q;
endmodule
